// File: rtl/loader_pkg.sv
// Shared types and constants for the CMD-file loader and its RAM bridge.
package loader_pkg;

    localparam int unsigned LOADER_ADDR_W = 16;
    localparam int unsigned LOADER_DATA_W = 8;

    // Byte offsets of the execute address inside a CMD transfer-address record
    localparam int unsigned SYSTEM_ENTRY_LSB = 0;
    localparam int unsigned SYSTEM_ENTRY_MSB = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } bridge_state_t;

    typedef struct packed {
        logic [LOADER_ADDR_W-1:0] addr;
        logic [LOADER_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/loader_wr_fifo.sv
// Small synchronous FIFO for buffered loader writes; a push on a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module loader_wr_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count_nxt_c,
    output logic [W-1:0]             head_c
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign pop_ok  = pop && !empty_c;
    assign push_ok = push && (!full_c || pop_ok);
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_nxt_c = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt_c = count + CNT_W'(1);
            2'b01:   count_nxt_c = count - CNT_W'(1);
            default: count_nxt_c = count;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt_c;
        end
    end

    // Storage carries no reset; only pointers define validity
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/loader_ram_bridge.sv
// Buffers loader write pulses and replays them to the shared RAM port via
// req/ack while the CPU is idle; holds the CPU and launches the program.
module loader_ram_bridge
    import loader_pkg::*;
#(
    parameter int unsigned ADDR  = 16,
    parameter int unsigned DATA  = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            loader_wr,
    input  logic [ADDR-1:0] loader_addr,
    input  logic [DATA-1:0] loader_data,
    input  logic            loader_download,
    input  logic            execute_enable,
    input  logic [ADDR-1:0] execute_addr,
    input  logic            cpu_mem_busy,
    output logic            ram_req,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_data,
    input  logic            ram_ack,
    output logic            fifo_almost_full,
    output logic            cpu_wait,
    output logic            jump_req,
    output logic [ADDR-1:0] jump_addr,
    output logic            overflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR + DATA;

    bridge_state_t    state;
    bridge_state_t    state_nxt;
    logic             pop;
    logic             drop;
    logic             full_c;
    logic             empty_c;
    logic [CNT_W-1:0] count_nxt_c;
    logic [ENT_W-1:0] head_c;
    logic             download_q;
    logic             download_rise;
    logic             jump_fire;
    logic             exec_pending;
    logic             exec_pending_nxt;

    loader_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (loader_wr),
        .pop         (pop),
        .din         ({loader_addr, loader_data}),
        .full_c      (full_c),
        .empty_c     (empty_c),
        .count_nxt_c (count_nxt_c),
        .head_c      (head_c)
    );

    assign pop           = (state == REQ) && ram_ack;
    assign drop          = loader_wr && full_c && !pop;
    assign download_rise = loader_download && !download_q;
    assign jump_fire     = exec_pending && !loader_download && empty_c &&
                           (state == IDLE) && !execute_enable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        exec_pending_nxt = exec_pending;
        case (state)
            IDLE:    if (!empty_c && !cpu_mem_busy) state_nxt = REQ;
            REQ:     if (ram_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (execute_enable)                  exec_pending_nxt = 1'b1;
        else if (download_rise || jump_fire) exec_pending_nxt = 1'b0;
    end

    // cpu_wait looks at post-edge values so it falls together with jump_req
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_req          <= 1'b0;
            ram_addr         <= '0;
            ram_data         <= '0;
            fifo_almost_full <= 1'b0;
            cpu_wait         <= 1'b0;
            jump_req         <= 1'b0;
            jump_addr        <= '0;
            overflow         <= 1'b0;
            exec_pending     <= 1'b0;
            download_q       <= 1'b0;
        end else begin
            ram_req          <= (state_nxt == REQ);
            fifo_almost_full <= (count_nxt_c >= CNT_W'(DEPTH - 2));
            cpu_wait         <= loader_download || (count_nxt_c != '0) ||
                                (state_nxt != IDLE) || exec_pending_nxt;
            jump_req         <= jump_fire;
            exec_pending     <= exec_pending_nxt;
            download_q       <= loader_download;
            if ((state == IDLE) && (state_nxt == REQ)) begin
                ram_addr <= head_c[ENT_W-1:DATA];
                ram_data <= head_c[DATA-1:0];
            end
            if (execute_enable)     jump_addr <= execute_addr;
            if (drop)               overflow  <= 1'b1;
            else if (download_rise) overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_loader_ram_bridge.sv
// Directed self-checking bench for loader_ram_bridge.
module tb_loader_ram_bridge;
    import loader_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        loader_wr = 1'b0;
    logic [15:0] loader_addr = '0;
    logic [7:0]  loader_data = '0;
    logic        loader_download = 1'b0;
    logic        execute_enable = 1'b0;
    logic [15:0] execute_addr = '0;
    logic        cpu_mem_busy = 1'b0;
    logic        ram_req;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_ack = 1'b0;
    logic        fifo_almost_full;
    logic        cpu_wait;
    logic        jump_req;
    logic [15:0] jump_addr;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    loader_ram_bridge #(.ADDR(16), .DATA(8), .DEPTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .loader_wr        (loader_wr),
        .loader_addr      (loader_addr),
        .loader_data      (loader_data),
        .loader_download  (loader_download),
        .execute_enable   (execute_enable),
        .execute_addr     (execute_addr),
        .cpu_mem_busy     (cpu_mem_busy),
        .ram_req          (ram_req),
        .ram_addr         (ram_addr),
        .ram_data         (ram_data),
        .ram_ack          (ram_ack),
        .fifo_almost_full (fifo_almost_full),
        .cpu_wait         (cpu_wait),
        .jump_req         (jump_req),
        .jump_addr        (jump_addr),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        loader_wr   = 1'b1;
        loader_addr = a;
        loader_data = d;
        step();
        loader_wr   = 1'b0;
    endtask

    task automatic drain_one(input logic [15:0] a, input logic [7:0] d, input int delay);
        int n;
        n = 0;
        while (!ram_req && n < 20) begin
            step();
            n++;
        end
        check("req_seen", 32'(ram_req), 32'd1);
        check("req_addr", 32'(ram_addr), 32'(a));
        check("req_data", 32'(ram_data), 32'(d));
        repeat (delay) step();
        ram_ack = 1'b1;
        step();
        ram_ack = 1'b0;
        check("req_drop", 32'(ram_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        wr_entry_t ent;
        int        acks;
        int        jumps;
        logic      early_drop;

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_ram_req", 32'(ram_req), 32'd0);
        check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        check("rst_jump_req", 32'(jump_req), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_almost_full", 32'(fifo_almost_full), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_jump_addr", 32'(jump_addr), 32'd0);
        #5 reset = 1'b0;
        step();

        // Single write: request two edges after the strobe
        loader_download = 1'b1;
        step();
        ent.addr = 16'h5200;
        ent.data = 8'hC3;
        push(ent.addr, ent.data);
        check("single_req_e0", 32'(ram_req), 32'd0);
        check("single_wait", 32'(cpu_wait), 32'd1);
        step();
        check("single_req_e1", 32'(ram_req), 32'd1);
        check("single_addr", 32'(ram_addr), 32'h5200);
        check("single_data", 32'(ram_data), 32'hC3);
        ram_ack = 1'b1;
        step();
        ram_ack = 1'b0;
        check("single_req_low", 32'(ram_req), 32'd0);
        check("single_wait_dl", 32'(cpu_wait), 32'd1);
        loader_download = 1'b0;
        step();
        check("single_wait_off", 32'(cpu_wait), 32'd0);
        check("single_req_idle", 32'(ram_req), 32'd0);

        // Burst of 9 with RAM blocked: almost_full at 6, ninth dropped
        loader_download = 1'b1;
        cpu_mem_busy    = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            push(16'h6000 + 16'(i), 8'h10 + 8'(i));
            check("burst_af", 32'(fifo_almost_full), 32'(i >= 5));
            check("burst_ovf", 32'(overflow), 32'(i == 8));
            check("burst_noreq", 32'(ram_req), 32'd0);
        end
        cpu_mem_busy = 1'b0;
        for (int k = 0; k < 8; k++) drain_one(16'h6000 + 16'(k), 8'h10 + 8'(k), 2);
        repeat (3) step();
        check("burst_empty_req", 32'(ram_req), 32'd0);
        check("burst_af_clear", 32'(fifo_almost_full), 32'd0);
        check("burst_ovf_sticky", 32'(overflow), 32'd1);
        loader_download = 1'b0;
        step();

        // CPU busy window with two queued entries
        loader_download = 1'b1;
        step();
        check("newdl_ovf_clear", 32'(overflow), 32'd0);
        cpu_mem_busy = 1'b1;
        push(16'h3000, 8'hA1);
        push(16'h3001, 8'hA2);
        for (int c = 0; c < 10; c++) begin
            step();
            check("busy_noreq", 32'(ram_req), 32'd0);
        end
        cpu_mem_busy = 1'b0;
        step();
        check("busy_release_req", 32'(ram_req), 32'd1);
        drain_one(16'h3000, 8'hA1, 0);
        drain_one(16'h3001, 8'hA2, 0);

        // Execute with pending writes; second strobe overwrites address
        cpu_mem_busy = 1'b1;
        push(16'h7000, 8'h01);
        push(16'h7001, 8'h02);
        push(16'h7002, 8'h03);
        execute_enable = 1'b1;
        execute_addr   = 16'h1234;
        step();
        execute_addr   = 16'h5200;
        step();
        execute_enable  = 1'b0;
        loader_download = 1'b0;
        cpu_mem_busy    = 1'b0;
        acks       = 0;
        jumps      = 0;
        early_drop = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ram_ack = ram_req;
            step();
            if (ram_ack) acks++;
            if (jump_req) begin
                jumps++;
                check("jump_after_acks", 32'(acks), 32'd3);
                check("jump_addr", 32'(jump_addr), 32'h5200);
                check("jump_wait_low", 32'(cpu_wait), 32'd0);
            end else if (jumps == 0 && !cpu_wait) begin
                early_drop = 1'b1;
            end
        end
        ram_ack = 1'b0;
        check("jump_once", 32'(jumps), 32'd1);
        check("wait_held", 32'(early_drop), 32'd0);
        check("jump_pulse_end", 32'(jump_req), 32'd0);

        // Async reset while a request is outstanding
        loader_download = 1'b1;
        step();
        push(16'h4100, 8'h77);
        step();
        check("prereset_req", 32'(ram_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_req", 32'(ram_req), 32'd0);
        check("midrst_wait", 32'(cpu_wait), 32'd0);
        check("midrst_addr", 32'(ram_addr), 32'd0);
        check("midrst_af", 32'(fifo_almost_full), 32'd0);
        loader_download = 1'b0;
        #2 reset = 1'b0;
        step();
        check("postrst_idle", 32'(ram_req), 32'd0);
        loader_download = 1'b1;
        step();
        push(16'h4000, 8'h55);
        step();
        check("postrst_req", 32'(ram_req), 32'd1);
        check("postrst_addr", 32'(ram_addr), 32'h4000);
        ram_ack = 1'b1;
        step();
        ram_ack = 1'b0;

        // Push and ack on the same edge with a full FIFO
        cpu_mem_busy = 1'b1;
        for (int i = 0; i < 8; i++) push(16'h8000 + 16'(i), 8'h80 + 8'(i));
        check("full_no_ovf", 32'(overflow), 32'd0);
        cpu_mem_busy = 1'b0;
        step();
        check("full_req", 32'(ram_req), 32'd1);
        check("full_head", 32'(ram_addr), 32'h8000);
        ram_ack     = 1'b1;
        loader_wr   = 1'b1;
        loader_addr = 16'h8008;
        loader_data = 8'h88;
        step();
        ram_ack   = 1'b0;
        loader_wr = 1'b0;
        check("simul_no_ovf", 32'(overflow), 32'd0);
        check("simul_af", 32'(fifo_almost_full), 32'd1);
        for (int k = 1; k < 9; k++) drain_one(16'h8000 + 16'(k), 8'h80 + 8'(k), 0);
        repeat (3) step();
        check("simul_drained", 32'(ram_req), 32'd0);
        loader_download = 1'b0;
        step();
        check("final_wait", 32'(cpu_wait), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
